// File: rtl/axi_conv_result_tx_if.sv
// axi_conv_result_tx_if
// Groups the controller-side push handshake and the AXI4-Stream master
// channel of axi_conv_result_tx. The design drives the "master" modport;
// the controller/DMA side (or a bench) uses "slave".
//
// Handshakes: a transfer happens on a rising clock edge where the sender's
// valid (controller_has_data / M_AXIS_TVALID) and the receiver's ready
// (controller_tx_ready / M_AXIS_TREADY) are both high; once the stream
// side raises TVALID it holds TVALID, TDATA and TLAST until TREADY is seen.
interface axi_conv_result_tx_if #(
    parameter int DATA_WIDTH = 16
);
    logic                    controller_has_data;
    logic [DATA_WIDTH-1:0]   controller_data;
    logic                    controller_tx_ready;
    logic                    M_AXIS_TVALID;
    logic [DATA_WIDTH-1:0]   M_AXIS_TDATA;
    logic [DATA_WIDTH/8-1:0] M_AXIS_TSTRB;
    logic                    M_AXIS_TLAST;
    logic                    M_AXIS_TREADY;
    logic                    frame_done;

    modport master (
        input  controller_has_data,
        input  controller_data,
        output controller_tx_ready,
        output M_AXIS_TVALID,
        output M_AXIS_TDATA,
        output M_AXIS_TSTRB,
        output M_AXIS_TLAST,
        input  M_AXIS_TREADY,
        output frame_done
    );

    modport slave (
        output controller_has_data,
        output controller_data,
        input  controller_tx_ready,
        input  M_AXIS_TVALID,
        input  M_AXIS_TDATA,
        input  M_AXIS_TSTRB,
        input  M_AXIS_TLAST,
        output M_AXIS_TREADY,
        input  frame_done
    );
endinterface

// File: rtl/axi_conv_result_tx.sv
// axi_conv_result_tx
// AXI4-Stream master draining convolution result words toward a DMA S2MM
// channel. Words enter a FIFO through a valid/ready push, are popped into a
// single output register (TDATA/TLAST/TVALID) and leave as stream beats.
// Optional framing (beat counter, TLAST, frame_done) is built only when the
// macro CONV_TX_TLAST_EN is defined; otherwise the stream is unframed.
// o_dbg_state exposes the output-stage state (0 = EMPTY, 1 = HOLD).
module axi_conv_result_tx #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int FRAME_LEN  = 64
) (
    input  logic                 M_AXIS_ACLK,
    input  logic                 M_AXIS_ARESETN,
    axi_conv_result_tx_if.master bus,
    output logic                 o_dbg_state
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    // Reject parameter sets the pointer arithmetic cannot handle.
    if ((DATA_WIDTH % 8) != 0 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || FRAME_LEN < 1) begin : g_param_check
        $error("axi_conv_result_tx: illegal parameter combination");
    end

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic [DATA_WIDTH-1:0] r_tdata;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_fifo_ne;
    logic                  w_not_full;

    // Full blocks the writer even if a pop happens the same cycle: no bypass.
    assign w_not_full = (r_count != FULL_CNT);
    assign w_fifo_ne  = (r_count != '0);
    assign w_push     = bus.controller_has_data && w_not_full;

    assign bus.controller_tx_ready = w_not_full;
    assign bus.M_AXIS_TVALID       = (r_state == ST_HOLD);
    assign bus.M_AXIS_TDATA        = r_tdata;
    assign bus.M_AXIS_TSTRB        = '1;
    assign o_dbg_state             = r_state;

    // Output-stage next state and pop decision; TREADY only affects what is
    // loaded at the next edge, never TVALID in the current cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_fifo_ne) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (bus.M_AXIS_TREADY) begin
                    if (w_fifo_ne) begin
                        w_pop = 1'b1;
                    end else begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
            end
        endcase
    end

    // Output-stage state register.
    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FIFO storage; contents are meaningless until written so no reset.
    always_ff @(posedge M_AXIS_ACLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.controller_data;
        end
    end

    // FIFO pointers (wrap naturally, depth is a power of two) and occupancy.
    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Output data register: loaded only on a pop, so it holds under stall.
    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            r_tdata <= '0;
        end else if (w_pop) begin
            r_tdata <= r_mem[r_rd_ptr];
        end
    end

`ifdef CONV_TX_TLAST_EN
    localparam int BW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [BW-1:0] LAST_IDX = BW'(FRAME_LEN - 1);

    logic          w_accept;
    logic [BW-1:0] r_beat_cnt;
    logic [BW-1:0] w_beat_nxt;
    logic          r_tlast;
    logic          r_frame_done;

    assign w_accept         = (r_state == ST_HOLD) && bus.M_AXIS_TREADY;
    assign bus.M_AXIS_TLAST = r_tlast;
    assign bus.frame_done   = r_frame_done;

    // Beat index after this edge; it is also the index of any word loaded
    // at this edge, which is what TLAST must reflect.
    always_comb begin
        w_beat_nxt = r_beat_cnt;
        if (w_accept) begin
            w_beat_nxt = (r_beat_cnt == LAST_IDX) ? '0 : r_beat_cnt + BW'(1);
        end
    end

    // Beat counter, TLAST captured at load time, frame_done pulse.
    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            r_beat_cnt   <= '0;
            r_tlast      <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_beat_cnt   <= w_beat_nxt;
            r_frame_done <= w_accept && r_tlast;
            if (w_pop) begin
                r_tlast <= (w_beat_nxt == LAST_IDX);
            end
        end
    end
`else
    assign bus.M_AXIS_TLAST = 1'b0;
    assign bus.frame_done   = 1'b0;
`endif

endmodule

// File: tb/tb_axi_conv_result_tx.sv
// tb_axi_conv_result_tx
// Directed bench for axi_conv_result_tx (FRAME_LEN=4, FIFO_DEPTH=8).
// Expected framing follows CONV_TX_TLAST_EN: with it undefined, TLAST and
// frame_done must stay low while the data path behaves identically.
module tb_axi_conv_result_tx;

    localparam int W     = 16;
    localparam int DEPTH = 8;
    localparam int FLEN  = 4;
`ifdef CONV_TX_TLAST_EN
    localparam bit TLAST_EN = 1'b1;
`else
    localparam bit TLAST_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;
    logic dbg_state;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    axi_conv_result_tx_if #(.DATA_WIDTH(W)) bus_if ();

    axi_conv_result_tx #(
        .DATA_WIDTH(W),
        .FIFO_DEPTH(DEPTH),
        .FRAME_LEN (FLEN)
    ) dut (
        .M_AXIS_ACLK   (clk),
        .M_AXIS_ARESETN(rst_n),
        .bus           (bus_if),
        .o_dbg_state   (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int           n_total = 0;
    int           n_bad   = 0;
    int           out_idx = 0;
    int           n_fd    = 0;
    int           n_last  = 0;
    int           cyc     = 0;
    int           acc_cyc_q[$];
    bit           exp_fd  = 1'b0;
    bit           prev_hold = 1'b0;
    logic [W-1:0] prev_data;
    logic         prev_last;
    bit           mon_en  = 1'b0;
    bit           rnd_done;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- monitor: pops expected words as beats are accepted ----------------
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            out_idx   = 0;
            exp_fd    = 1'b0;
            prev_hold = 1'b0;
        end else if (mon_en) begin
            check("frame_done", {31'd0, bus_if.frame_done}, {31'd0, exp_fd});
            if (bus_if.frame_done === 1'b1) n_fd++;
            if (prev_hold) begin
                check("stall_tvalid", {31'd0, bus_if.M_AXIS_TVALID}, 32'd1);
                check("stall_tdata", {16'd0, bus_if.M_AXIS_TDATA}, {16'd0, prev_data});
                check("stall_tlast", {31'd0, bus_if.M_AXIS_TLAST}, {31'd0, prev_last});
            end
            exp_fd = 1'b0;
            if (bus_if.M_AXIS_TVALID === 1'b1 && bus_if.M_AXIS_TREADY === 1'b1) begin
                bit want_last;
                want_last = TLAST_EN && (out_idx == FLEN - 1);
                acc_cyc_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", {16'd0, bus_if.M_AXIS_TDATA}, 32'hFFFF_FFFF);
                end else begin
                    logic [W-1:0] e;
                    e = exp_q.pop_front();
                    check("beat_tdata", {16'd0, bus_if.M_AXIS_TDATA}, {16'd0, e});
                end
                check("beat_tlast", {31'd0, bus_if.M_AXIS_TLAST}, {31'd0, want_last});
                check("beat_tstrb", {30'd0, bus_if.M_AXIS_TSTRB}, 32'd3);
                if (bus_if.M_AXIS_TLAST === 1'b1) n_last++;
                exp_fd  = want_last;
                out_idx = (out_idx + 1) % FLEN;
            end
            prev_hold = (bus_if.M_AXIS_TVALID === 1'b1) && (bus_if.M_AXIS_TREADY === 1'b0);
            prev_data = bus_if.M_AXIS_TDATA;
            prev_last = bus_if.M_AXIS_TLAST;
        end
    end

    // ---------------- driver tasks ----------------
    // Presents d until handshaked; returns 1 ns after the accepting edge with
    // controller_has_data still high so streams stay back-to-back.
    task automatic push_word(input logic [W-1:0] d);
        int waited;
        bit done;
        waited = 0;
        done   = 1'b0;
        bus_if.controller_has_data = 1'b1;
        bus_if.controller_data     = d;
        while (!done && waited < 200) begin
            @(negedge clk);
            if (bus_if.controller_tx_ready === 1'b1) begin
                exp_q.push_back(d);
                done = 1'b1;
            end else begin
                waited++;
            end
        end
        @(posedge clk);
        #1;
        if (!done) begin
            bus_if.controller_has_data = 1'b0;
            check("push_timeout", 32'd0, 32'd1);
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus_if.M_AXIS_TVALID === 1'b1) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_drain"}, {31'd0, (n < 300)}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus_if.controller_has_data = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tvalid"}, {31'd0, bus_if.M_AXIS_TVALID}, 32'd0);
        check({tag, "_tdata"}, {16'd0, bus_if.M_AXIS_TDATA}, 32'd0);
        check({tag, "_tlast"}, {31'd0, bus_if.M_AXIS_TLAST}, 32'd0);
        check({tag, "_frame_done"}, {31'd0, bus_if.frame_done}, 32'd0);
        check({tag, "_tx_ready"}, {31'd0, bus_if.controller_tx_ready}, 32'd1);
        check({tag, "_state"}, {31'd0, dbg_state}, 32'd0);
    endtask

    // Global bound so the run always ends.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int last0;
        int fd0;
        rst_n                      = 1'b0;
        bus_if.controller_has_data = 1'b0;
        bus_if.controller_data     = '0;
        bus_if.M_AXIS_TREADY       = 1'b0;

        // Reset values.
        @(negedge clk);
        check_reset_outputs("rst");
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Single word: visible two cycles after the handshake cycle.
        bus_if.M_AXIS_TREADY = 1'b1;
        push_word(16'h00A5);
        bus_if.controller_has_data = 1'b0;
        @(negedge clk);
        check("single_early_tvalid", {31'd0, bus_if.M_AXIS_TVALID}, 32'd0);
        @(negedge clk);
        check("single_tvalid", {31'd0, bus_if.M_AXIS_TVALID}, 32'd1);
        check("single_tdata", {16'd0, bus_if.M_AXIS_TDATA}, 32'h00A5);
        @(negedge clk);
        check("single_after_tvalid", {31'd0, bus_if.M_AXIS_TVALID}, 32'd0);
        check("single_after_tx_ready", {31'd0, bus_if.controller_tx_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Full FIFO under backpressure: 1 in the output register + 8 queued.
        bus_if.M_AXIS_TREADY = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            push_word(W'(i));
        end
        bus_if.controller_has_data = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("full_tx_ready", {31'd0, bus_if.controller_tx_ready}, 32'd0);
            check("full_hold_tdata", {16'd0, bus_if.M_AXIS_TDATA}, 32'd1);
        end
        @(posedge clk);
        #1;
        bus_if.M_AXIS_TREADY = 1'b1;
        drain("full");
        check("full_all_out", exp_q.size(), 32'd0);

        // Back-to-back framing from a clean frame start.
        do_reset();
        bus_if.M_AXIS_TREADY = 1'b1;
        acc_cyc_q.delete();
        last0 = n_last;
        fd0   = n_fd;
        for (int i = 0; i < 8; i++) begin
            push_word(W'(i));
        end
        bus_if.controller_has_data = 1'b0;
        drain("frame");
        check("frame_beats", acc_cyc_q.size(), 32'd8);
        if (acc_cyc_q.size() == 8) begin
            check("frame_throughput", acc_cyc_q[7] - acc_cyc_q[0], 32'd7);
        end
        check("frame_tlast_count", n_last - last0, TLAST_EN ? 32'd2 : 32'd0);
        check("frame_done_count", n_fd - fd0, TLAST_EN ? 32'd2 : 32'd0);

        // Random TREADY and random controller gaps.
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        bus_if.controller_has_data = 1'b0;
                        @(posedge clk);
                        #1;
                    end
                    push_word(W'(16'h1000 + i));
                end
                bus_if.controller_has_data = 1'b0;
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    bus_if.M_AXIS_TREADY = 1'($urandom_range(0, 1));
                end
            end
        join
        bus_if.M_AXIS_TREADY = 1'b1;
        drain("random");
        check("random_all_out", exp_q.size(), 32'd0);

        // Reset mid-frame with words buffered.
        do_reset();
        bus_if.M_AXIS_TREADY = 1'b1;
        push_word(16'h0020);
        push_word(16'h0021);
        bus_if.controller_has_data = 1'b0;
        drain("mid_pre");
        bus_if.M_AXIS_TREADY = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_word(W'(16'h0030 + i));
        end
        bus_if.controller_has_data = 1'b0;
        @(negedge clk);
        check("mid_hold_tvalid", {31'd0, bus_if.M_AXIS_TVALID}, 32'd1);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check_reset_outputs("mid_rst");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus_if.M_AXIS_TREADY = 1'b1;
        last0 = n_last;
        for (int i = 0; i < 4; i++) begin
            push_word(W'(16'h0040 + i));
        end
        bus_if.controller_has_data = 1'b0;
        drain("mid_post");
        check("mid_post_tlast_count", n_last - last0, TLAST_EN ? 32'd1 : 32'd0);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/axi_conv_result_tx.md
# axi_conv_result_tx

AXI4-Stream master that carries convolution results out of the fabric, the transmit-side counterpart of the stream slave that feeds the convolution controller. The controller pushes result words through a simple valid/ready handshake into a small FIFO. The block drains them as `M_AXIS` beats toward the DMA S2MM channel, and frames each result block with TLAST.

## Interface
Parameters:
- `DATA_WIDTH`, 16: result word width; must be a multiple of 8.
- `FIFO_DEPTH`, 8: result FIFO entries; power of 2, ≥2.
- `FRAME_LEN`, 64: beats per frame; ≥1.

Ports:
- `M_AXIS_ACLK` in 1: single clock.
- `M_AXIS_ARESETN` in 1: reset, asynchronous, active-low.
- `controller_has_data` in 1: controller presents a result word.
- `controller_data` in DATA_WIDTH: result word.
- `controller_tx_ready` out 1: block can accept a word; transfer occurs when `controller_has_data && controller_tx_ready`.
- `M_AXIS_TVALID` out 1: output beat valid.
- `M_AXIS_TDATA` out DATA_WIDTH: output beat data.
- `M_AXIS_TSTRB` out DATA_WIDTH/8: byte strobes.
- `M_AXIS_TLAST` out 1: last beat of frame.
- `M_AXIS_TREADY` in 1: downstream accepts the beat.
- `frame_done` out 1: one-cycle pulse after the last beat of a frame is accepted.

## Operation
- Write side:
  - `controller_tx_ready = (count != FIFO_DEPTH)`, combinational from registered count.
  - On the handshake, the word is written at the write pointer, the pointer increments, and it wraps modulo FIFO_DEPTH.
- Output stage: a single register holding TDATA, TLAST and TVALID.
- State machine, 2 states:
  - EMPTY: TVALID=0. If the FIFO is non-empty, pop the head into the output register and go to HOLD.
  - HOLD: TVALID=1 and the beat is held stable.
    - On `TREADY=1` with the FIFO non-empty: pop the next word and stay in HOLD (back-to-back).
    - On `TREADY=1` with the FIFO empty: go to EMPTY.
    - On `TREADY=0`: no change.
- Occupancy `count` (0..FIFO_DEPTH) tracks FIFO entries only, not the output register.
  - Push and pop in the same cycle: count unchanged.
  - When full, `controller_tx_ready`=0 even if a pop occurs that cycle; there is no same-cycle bypass.
- Beat counter `beat_cnt` (width clog2(FRAME_LEN), min 1):
  - Increments on each accepted beat (`TVALID && TREADY`).
  - Wraps to 0 after FRAME_LEN−1.
  - TLAST is computed when a word is loaded into the output register, as (`beat_cnt` of that beat == FRAME_LEN−1).
  - FRAME_LEN=1 gives TLAST on every beat.
- TSTRB is constant all-ones.
- AXI rule: TDATA, TLAST and TVALID never change while `TVALID=1 && TREADY=0`. TVALID never depends combinationally on TREADY.
- Word order out equals word order in. No word is dropped or duplicated.

## Timing
Reset values (async assert, synchronous-release behaviour at first edge):
- `M_AXIS_TVALID`=0, `M_AXIS_TDATA`=0, `M_AXIS_TLAST`=0, `frame_done`=0.
- `controller_tx_ready`=1.
- Pointers and `count` = 0, `beat_cnt`=0, state EMPTY.

Cycle-level behaviour:
- Latency: a word handshaked at edge k is loaded into the output register at edge k+1. TVALID is high after edge k+1, so it is visible 2 cycles after the handshake cycle.
- Throughput: 1 beat/cycle sustained with TREADY held high and the controller streaming.
- `frame_done` is high for exactly the cycle following the edge that accepted the TLAST beat.
- Reset mid-frame:
  - All buffered words are discarded and `beat_cnt` returns to 0.
  - The next frame starts fresh.
  - TVALID drops immediately on assertion of reset.

## Configuration
Macro `CONV_TX_TLAST_EN`:
- Defined: `beat_cnt`, TLAST generation and `frame_done` behave as above.
- Undefined:
  - The beat counter is not built.
  - `M_AXIS_TLAST` is tied 0 and `frame_done` is tied 0.
  - The stream is unframed.
  - All other behaviour is identical.

## Test plan
- Single word: reset, push 0x00A5 with TREADY=1 → TVALID high 2 cycles after the handshake with TDATA=0x00A5 and TSTRB=2'b11. Then TVALID=0 and `controller_tx_ready`=1.
- Full and backpressure: TREADY=0, push 9 words 1..9 → `controller_tx_ready` drops after the 8th FIFO entry. Output holds word 1 stable for ≥10 cycles. On releasing TREADY, beats 1..9 are emitted in order with none lost.
- Back-to-back framing:
  - Setup: FRAME_LEN=4, TREADY=1, push 0..7 continuously.
  - Required: TLAST on the beats carrying 3 and 7 only.
  - Required: `frame_done` pulses once, the cycle after each of those beats.
  - Required: 1 beat/cycle once streaming.
- Random TREADY: 200 sequential words, TREADY toggled pseudo-randomly, controller valid toggled randomly. Checks:
  - Scoreboard shows exact in-order match.
  - TDATA/TLAST unchanged whenever TVALID && !TREADY.
- Reset mid-frame:
  - Setup: FRAME_LEN=4; send 2 beats; assert reset with 3 words buffered.
  - Required: outputs reach reset values immediately.
  - Required: after release, a new push of 4 words gives TLAST on the 4th word.
- Macro off: build without `CONV_TX_TLAST_EN` and rerun the framing scenario → same data, TLAST and `frame_done` never asserted.
